// File: rtl/z80_io_cycle_master.sv
// Z80-style I/O cycle initiator: T1, T2, optional TWA, TW, T3.
// Drives IORQ/RD/WR, honours WAIT_n and aborts on a stuck wait.
module z80_io_cycle_master #(
  parameter int AUTO_WAIT = 1,
  parameter int MAX_WAIT  = 255
) (
  input  logic        i_reset,
  input  logic        i_clk,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_rdata,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dout,
  output logic        o_dout_oe,
  output logic        o_iorq_n,
  output logic        o_rd_n,
  output logic        o_wr_n,
  input  logic        i_wait_n,
  input  logic [7:0]  i_din
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TWA  = 3'd3;
  localparam logic [2:0] S_TW   = 3'd4;
  localparam logic [2:0] S_T3   = 3'd5;

  localparam logic [7:0] MAXW = 8'(MAX_WAIT);
  localparam bit TMO_EN = (MAX_WAIT != 0);
  localparam bit AW_EN  = (AUTO_WAIT != 0);

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        terr_q, terr_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        iorq_q, iorq_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [7:0]  cnt_inc;

  // Counter saturates so the no-timeout build never wraps.
  assign cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    iorq_d  = iorq_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (i_req) begin
          we_d   = i_we;
          addr_d = i_addr;
          if (i_we) begin
            dout_d = i_wdata;
            oe_d   = 1'b1;
          end
          state_d = S_T1;
        end
      end
      (state_q == S_T1): begin
        iorq_d  = 1'b0;
        rd_d    = we_q;
        wr_d    = ~we_q;
        state_d = S_T2;
      end
      (state_q == S_T2): begin
        cnt_d   = 8'd0;
        terr_d  = 1'b0;
        state_d = AW_EN ? S_TWA : S_TW;
      end
      (state_q == S_TWA): begin
        state_d = S_TW;
      end
      (state_q == S_TW): begin
        if (i_wait_n) begin
          if (!we_q) rdata_d = i_din;
          iorq_d  = 1'b1;
          rd_d    = 1'b1;
          wr_d    = 1'b1;
          terr_d  = 1'b0;
          state_d = S_T3;
        end else begin
          cnt_d = cnt_inc;
          if (TMO_EN && cnt_inc == MAXW) begin
            iorq_d  = 1'b1;
            rd_d    = 1'b1;
            wr_d    = 1'b1;
            terr_d  = 1'b1;
            state_d = S_T3;
          end
        end
      end
      (state_q == S_T3): begin
        oe_d    = 1'b0;
        done_d  = 1'b1;
        err_d   = terr_q;
        state_d = S_IDLE;
      end
      default: begin
        iorq_d  = 1'b1;
        rd_d    = 1'b1;
        wr_d    = 1'b1;
        oe_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      cnt_q   <= 8'd0;
      terr_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'd0;
      addr_q  <= 16'd0;
      dout_q  <= 8'd0;
      oe_q    <= 1'b0;
      iorq_q  <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      iorq_q  <= iorq_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_rdata   = rdata_q;
  assign o_addr    = addr_q;
  assign o_dout    = dout_q;
  assign o_dout_oe = oe_q;
  assign o_iorq_n  = iorq_q;
  assign o_rd_n    = rd_q;
  assign o_wr_n    = wr_q;

endmodule

// File: doc/z80_io_cycle_master.md
Name: z80_io_cycle_master

Overview:
- Bus initiator that runs Z80-style I/O read/write cycles (T1, T2, automatic TW, extended TW, T3) from a simple command interface.
- Drives IORQ_n, RD_n and WR_n, and honours WAIT_n from slave-side wait-state logic.
- Used by the DMA/test-master path to reach I/O devices on the same bus and with the same timing as the CPU.
- Includes a wait timeout so a stuck WAIT_n cannot hang the master.

Parameters:
AUTO_WAIT, 1, 1 = insert one unconditional TWA state after T2 (Z80 I/O behaviour); 0 = go straight from T2 to TW.
MAX_WAIT, 255, 1..255 = abort the cycle after this many consecutive TW samples with i_wait_n low; 0 = no timeout.

Ports:
i_reset  in  1  asynchronous, active-high reset
i_clk  in  1  bus clock; all logic is on the rising edge
i_req  in  1  command strobe; accepted when i_req & o_ready
i_we  in  1  1 = I/O write, 0 = I/O read
i_addr  in  16  I/O address
i_wdata  in  8  write data
o_ready  out  1  high only in IDLE
o_done  out  1  one-cycle pulse on cycle completion
o_err  out  1  valid with o_done; 1 = wait timeout
o_rdata  out  8  read data; held until the next successful read
o_addr  out  16  bus address
o_dout  out  8  bus write data
o_dout_oe  out  1  data-bus output enable
o_iorq_n  out  1  I/O request, active low
o_rd_n  out  1  read strobe, active low
o_wr_n  out  1  write strobe, active low
i_wait_n  in  1  wait from slaves, active low, synchronous to i_clk
i_din  in  8  bus read data

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-cycle):
  - State = IDLE.
  - o_iorq_n, o_rd_n, o_wr_n = 1; o_dout_oe = 0; o_done = 0; o_err = 0.
  - o_addr, o_dout, o_rdata = 0; wait counter = 0.
  - No o_done pulse is generated for an aborted cycle.
- All outputs are registered.
- States: IDLE, T1, T2, TWA, TW, T3.
- IDLE:
  - o_ready = 1.
  - On an edge with i_req = 1: latch i_we; o_addr <= i_addr; if write, o_dout <= i_wdata and o_dout_oe <= 1. Go to T1.
  - i_req while not IDLE is ignored; no queuing.
- T1 (1 cycle): strobes stay high. On exit to T2: o_iorq_n <= 0; o_rd_n <= i_we_latched; o_wr_n <= ~i_we_latched.
- T2 (1 cycle): go to TWA if AUTO_WAIT = 1, else to TW. Clear the wait counter.
- TWA (1 cycle): i_wait_n is ignored; go to TW.
- TW, evaluated at each edge:
  - i_wait_n = 1: if read, o_rdata <= i_din. Deassert o_iorq_n, o_rd_n, o_wr_n. Go to T3 with err flag = 0.
  - i_wait_n = 0: increment the counter. If MAX_WAIT != 0 and the counter reaches MAX_WAIT, deassert the strobes, go to T3 with err flag = 1, and leave o_rdata unchanged. Otherwise stay in TW.
- T3 (1 cycle): on exit to IDLE:
  - o_dout_oe <= 0.
  - o_done <= 1 for exactly one cycle; o_err <= err flag.
  - o_addr and o_dout hold their values.
- Timing, AUTO_WAIT = 1, no extra waits:
  - Request accepted at edge E0 → T1, T2, TWA, TW → T3 entered at E4 → o_done high in the cycle after E5.
  - o_iorq_n is low for 3 cycles (T2, TWA, TW).
  - Each extra low wait sample adds 1 cycle.
- Back-to-back: o_ready = 1 during the o_done cycle, and a request accepted in that cycle starts T1 immediately. Minimum spacing is 6 cycles.
- Counter width is 8 bits and never wraps: the timeout fires at 255 first. With MAX_WAIT = 0 the counter saturates at 255 and the master waits forever.
- o_rd_n and o_wr_n are never low at the same time. Strobes are only low while o_iorq_n is low.

Test Plan:
- AUTO_WAIT=1, read 0x0042, i_wait_n held high, i_din=0xA5 → o_iorq_n/o_rd_n low for exactly 3 cycles; o_wr_n stays 1; o_done 6 cycles after acceptance; o_rdata=0xA5; o_err=0.
- Write 0x0010 ← 0x3C, i_wait_n low for 2 TW samples → o_wr_n low 5 cycles; o_dout=0x3C with o_dout_oe=1 from T1 through T3; o_done 8 cycles after acceptance; o_rdata unchanged.
- MAX_WAIT=4, read with i_wait_n stuck low → strobes released after the 4th TW sample; o_done with o_err=1; o_rdata keeps its previous value; next command runs normally.
- Assert i_reset while in TW of a read → strobes high and o_dout_oe=0 immediately; no o_done; o_ready=1 after release.
- Two reads issued with i_req held high → second T1 begins in the cycle after the first o_done; no gap or overlap in strobes; i_req raised mid-cycle is ignored.
- AUTO_WAIT=0, read with i_wait_n high → o_iorq_n low for 2 cycles; o_done 5 cycles after acceptance; i_wait_n low only during T2 has no effect.
